pcileech_bar_req_master: RTL and testbench
==========================================

PCILEECH_BAR_REQ_MASTER -- requirements
Module: pcileech_bar_req_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the RD_WAIT cycles (including the first wait cycle) before a read is abandoned; legal range 2..65535.
REQ-002 SHALL have the ports below; reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- base_address_register  in  32  BAR base, bits [3:0] are flags.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_offset  in  11  byte offset in BAR, bits [1:0] ignored.
- cmd_be  in  4  write byte enables.
- cmd_data  in  32  write data.
- cmd_tag  in  8  caller tag echoed on result.
- wr_addr / wr_be / wr_data / wr_valid  out  32/4/32/1  BAR write request.
- rd_req_ctx / rd_req_addr / rd_req_valid  out  88/32/1  BAR read request.
- rd_rsp_ctx / rd_rsp_data / rd_rsp_valid  in  88/32/1  BAR read reply.
- res_valid  out  1  one-cycle read result pulse, no backpressure.
- res_tag / res_data / res_timeout  out  8/32/1  result fields.
- busy  out  1  state != IDLE.
- timeout_count  out  16  saturating count of timed-out reads.
- stray_count  out  8  saturating count of unmatched replies.

Function
REQ-003 SHALL implement states IDLE, WR, RD_ISSUE, RD_WAIT, RESULT; cmd_ready=1 only in IDLE and not in rst.
REQ-004 SHALL form address = (base_address_register & 32'hFFFFFFF0) + {21'b0, cmd_offset[10:2], 2'b00}, modulo 2^32.
REQ-005 SHALL latch address, be, data, tag, write flag at acceptance (cycle N).
REQ-006 Write: IDLE->WR at N; wr_valid=1 with latched fields in N+1 only; WR->IDLE; cmd_ready=1 again at N+2; no result generated.
REQ-007 Read: IDLE->RD_ISSUE at N; rd_req_valid=1 in N+1 only, rd_req_addr=address, rd_req_ctx={72'h0, seq[7:0], tag[7:0]}; ->RD_WAIT with wait counter=0.
REQ-008 seq SHALL be an 8-bit counter incremented once per issued read, wrapping 255->0.
REQ-009 In RD_WAIT, rd_rsp_valid with rd_rsp_ctx[15:0]=={seq,tag} of the pending read SHALL capture rd_rsp_data and go to RESULT with res_timeout=0.
REQ-010 SHALL NOT compare rd_rsp_ctx[87:16].
REQ-011 In RD_WAIT, when the counter reaches TIMEOUT_CYCLES-1 with no match, SHALL go to RESULT with res_data=32'hFFFFFFFF, res_timeout=1, and increment timeout_count (saturate at 16'hFFFF).
REQ-012 A match in the same cycle as counter=TIMEOUT_CYCLES-1: match wins, no timeout counted.
REQ-013 Any rd_rsp_valid not matching the pending read, including all replies in IDLE/WR/RD_ISSUE/RESULT and late replies after timeout, SHALL increment stray_count (saturate at 8'hFF) and be otherwise ignored.
REQ-014 RESULT: res_valid=1 for exactly one cycle with res_tag=latched tag, then ->IDLE; read latency from acceptance = BAR reply latency + 2 cycles to res_valid.
REQ-015 res_data/res_tag/res_timeout SHALL hold their last values when res_valid=0.
REQ-016 At most one request outstanding; wr_valid and rd_req_valid SHALL never be asserted together.

Reset
REQ-017 While rst=1: state=IDLE, cmd_ready=0, wr_valid=0, rd_req_valid=0, res_valid=0, busy=0, seq=0, timeout_count=0, stray_count=0, all data/address/ctx outputs=0.
REQ-018 rst during any state SHALL abandon the pending request with no res_valid; a reply arriving after reset release counts as stray.
REQ-019 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-020 BAR=32'hF7C00004, write offset 0x050 data 32'h00010000 be 4'hF -> single wr_valid, wr_addr=32'hF7C00050, no res_valid.
REQ-021 Read offset 0x00C tag 8'h5A, BAR model replies 2 cycles later with 32'h3F -> res_valid 4 cycles after acceptance, res_data=32'h3F, res_tag=8'h5A, res_timeout=0, rd_req_ctx[15:0]=16'h005A.
REQ-022 Read with no reply, TIMEOUT_CYCLES=64 -> res_valid once, res_data=32'hFFFFFFFF, res_timeout=1, timeout_count=1; late reply then raises stray_count to 1.
REQ-023 Reply with wrong seq during RD_WAIT followed by correct reply -> stray_count+1, result carries correct data; reply on final wait cycle -> no timeout.
REQ-024 256 back-to-back reads -> seq wraps to 0, ctx[15:8] on read 257 is 8'h00, all results matched.
REQ-025 rst asserted in RD_WAIT -> no res_valid, counters=0, cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/pcileech_bar_req_master.sv
// ============================================================================
// Module   : pcileech_bar_req_master
// Brief    : Single-outstanding command master for a PCIe BAR. Turns one
//            command at a time into a BAR write or a tagged BAR read, waits
//            for the matching read reply (bounded by TIMEOUT_CYCLES), and
//            reports each read as a one-cycle result pulse. Unmatched replies
//            and abandoned reads are counted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcileech_bar_req_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] base_address_register,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [10:0] cmd_offset,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_data,
  input  logic [7:0]  cmd_tag,
  // BAR write request
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  // BAR read request
  output logic [87:0] rd_req_ctx,
  output logic [31:0] rd_req_addr,
  output logic        rd_req_valid,
  // BAR read reply
  input  logic [87:0] rd_rsp_ctx,
  input  logic [31:0] rd_rsp_data,
  input  logic        rd_rsp_valid,
  // read result
  output logic        res_valid,
  output logic [7:0]  res_tag,
  output logic [31:0] res_data,
  output logic        res_timeout,
  // status
  output logic        busy,
  output logic [15:0] timeout_count,
  output logic [7:0]  stray_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RESULT   = 3'd4
  } state_t;

  // Last wait-counter value before a read is given up.
  localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  // Command fields captured at acceptance. The write/read flag is carried by
  // the state the FSM enters (WR vs RD_ISSUE), so it needs no separate flop.
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_data;
  logic [7:0]  r_tag;
  logic [7:0]  r_pend_seq;   // sequence number owned by the pending read

  logic [7:0]  r_seq;        // next sequence number to hand out
  logic [15:0] r_wait_cnt;

  logic [7:0]  r_res_tag;
  logic [31:0] r_res_data;
  logic        r_res_timeout;
  logic [15:0] r_timeout_count;
  logic [7:0]  r_stray_count;

  logic [31:0] w_cmd_addr;
  logic        w_accept;
  logic        w_rsp_match;
  logic        w_timeout;
  logic        w_stray;

  // Flag bits of the BAR, the word-aligning offset bits and the caller-owned
  // upper reply context play no part in the datapath.
  logic        w_unused_bits;
  assign w_unused_bits = ^{base_address_register[3:0], cmd_offset[1:0],
                           rd_rsp_ctx[87:16]};

  assign w_cmd_addr  = (base_address_register & 32'hFFFF_FFF0)
                     + {21'b0, cmd_offset[10:2], 2'b00};
  assign w_accept    = cmd_valid && (r_state == S_IDLE) && !rst;
  assign w_rsp_match = (r_state == S_RD_WAIT) && rd_rsp_valid
                     && (rd_rsp_ctx[15:0] == {r_pend_seq, r_tag});
  // A reply on the final wait cycle beats the timeout.
  assign w_timeout   = (r_state == S_RD_WAIT) && !w_rsp_match
                     && (r_wait_cnt == c_WAIT_LAST);
  assign w_stray     = rd_rsp_valid && !w_rsp_match;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection and state-decoded outputs (all forced low in reset).
  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    wr_valid     = 1'b0;
    rd_req_valid = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = cmd_write ? S_WR : S_RD_ISSUE;
      S_WR:       w_state_nxt = S_IDLE;
      S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (w_rsp_match || w_timeout) w_state_nxt = S_RESULT;
      S_RESULT:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (!rst) begin
      cmd_ready    = (r_state == S_IDLE);
      busy         = (r_state != S_IDLE);
      wr_valid     = (r_state == S_WR);
      rd_req_valid = (r_state == S_RD_ISSUE);
      res_valid    = (r_state == S_RESULT);
    end
  end

  // Data and address outputs, held at zero while in reset.
  always_comb begin
    wr_addr       = '0;
    wr_be         = '0;
    wr_data       = '0;
    rd_req_addr   = '0;
    rd_req_ctx    = '0;
    res_tag       = '0;
    res_data      = '0;
    res_timeout   = 1'b0;
    timeout_count = '0;
    stray_count   = '0;
    if (!rst) begin
      wr_addr       = r_addr;
      wr_be         = r_be;
      wr_data       = r_data;
      rd_req_addr   = r_addr;
      rd_req_ctx    = {72'h0, r_pend_seq, r_tag};
      res_tag       = r_res_tag;
      res_data      = r_res_data;
      res_timeout   = r_res_timeout;
      timeout_count = r_timeout_count;
      stray_count   = r_stray_count;
    end
  end

  // Command capture, sequence numbering and the read wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_be       <= '0;
      r_data     <= '0;
      r_tag      <= '0;
      r_pend_seq <= '0;
      r_seq      <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= w_cmd_addr;
        r_be       <= cmd_be;
        r_data     <= cmd_data;
        r_tag      <= cmd_tag;
        r_pend_seq <= r_seq;
      end
      if (r_state == S_RD_ISSUE) begin
        r_seq      <= r_seq + 8'd1;
        r_wait_cnt <= '0;
      end else if (r_state == S_RD_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

  // Result capture (held between pulses) and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_tag       <= '0;
      r_res_data      <= '0;
      r_res_timeout   <= 1'b0;
      r_timeout_count <= '0;
      r_stray_count   <= '0;
    end else begin
      if (w_rsp_match) begin
        r_res_tag     <= r_tag;
        r_res_data    <= rd_rsp_data;
        r_res_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_res_tag     <= r_tag;
        r_res_data    <= 32'hFFFF_FFFF;
        r_res_timeout <= 1'b1;
        if (r_timeout_count != 16'hFFFF) begin
          r_timeout_count <= r_timeout_count + 16'd1;
        end
      end
      if (w_stray && (r_stray_count != 8'hFF)) begin
        r_stray_count <= r_stray_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcileech_bar_req_master.sv
// ============================================================================
// Module   : tb_pcileech_bar_req_master
// Brief    : Directed bench for pcileech_bar_req_master. A transaction-level
//            model predicts, per accepted command, the cycles on which write
//            requests, read requests and results must appear, which replies
//            are strays, and the counter values; a compare process checks the
//            DUT against it every cycle. Literal checks pin key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcileech_bar_req_master;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] base_address_register = 32'hF7C0_0004;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [10:0] cmd_offset = '0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_data = '0;
  logic [7:0]  cmd_tag = '0;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic [87:0] rd_req_ctx;
  logic [31:0] rd_req_addr;
  logic        rd_req_valid;
  logic [87:0] rd_rsp_ctx = '0;
  logic [31:0] rd_rsp_data = '0;
  logic        rd_rsp_valid = 1'b0;
  logic        res_valid;
  logic [7:0]  res_tag;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        busy;
  logic [15:0] timeout_count;
  logic [7:0]  stray_count;

  pcileech_bar_req_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .base_address_register(base_address_register),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_offset(cmd_offset), .cmd_be(cmd_be), .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
    .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_timeout(res_timeout),
    .busy(busy), .timeout_count(timeout_count), .stray_count(stray_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [31:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] addr; logic [87:0] ctx; } rq_t;
  typedef struct packed { logic [7:0] tag; logic [31:0] data; logic tmo; } res_t;
  typedef struct packed { logic [87:0] ctx; logic [31:0] data; } rsp_t;

  // Expected events keyed by cycle number.
  wr_t  exp_wr[int];
  rq_t  exp_rq[int];
  res_t exp_res[int];
  bit   exp_busy[int];
  rsp_t rsp_sched[int];
  bit   stray_evt[int];

  logic [7:0]  m_seq = '0;
  int          m_free_at = 0;
  logic [7:0]  m_stray = '0;
  logic [15:0] m_tmo = '0;
  res_t        m_last = '0;
  logic        prev_rst = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] bar_addr(input logic [31:0] bar, input logic [10:0] off);
    logic [31:0] o;
    o = 32'(off);
    return (bar / 32'd16) * 32'd16 + (o / 32'd4) * 32'd4;
  endfunction

  // Advance one cycle and drive the reply scheduled for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (rsp_sched.exists(cyc)) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_ctx   = rsp_sched[cyc].ctx;
      rd_rsp_data  = rsp_sched[cyc].data;
    end else begin
      rd_rsp_valid = 1'b0;
      rd_rsp_ctx   = '0;
      rd_rsp_data  = '0;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Reply with junk in the caller-owned upper context bits.
  task automatic sched(input int c, input logic [15:0] lo, input logic [31:0] d);
    rsp_t r;
    r.ctx  = {72'hA5_1234_5678_9ABC_DEF0, lo};
    r.data = d;
    rsp_sched[c] = r;
    stray_evt[c] = 1'b1;
  endtask

  task automatic clear_from(input int k);
    int keys[$];
    keys = {}; foreach (exp_wr[i])   if (i >= k) keys.push_back(i);
    foreach (keys[j]) exp_wr.delete(keys[j]);
    keys = {}; foreach (exp_rq[i])   if (i >= k) keys.push_back(i);
    foreach (keys[j]) exp_rq.delete(keys[j]);
    keys = {}; foreach (exp_res[i])  if (i >= k) keys.push_back(i);
    foreach (keys[j]) exp_res.delete(keys[j]);
    keys = {}; foreach (exp_busy[i]) if (i >= k) keys.push_back(i);
    foreach (keys[j]) exp_busy.delete(keys[j]);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    clear_from(cyc);
    m_seq = '0;
    repeat (ncyc) tick();
    rst = 1'b0;
    m_free_at = cyc;
  endtask

  task automatic issue_write(input logic [10:0] off, input logic [3:0] be,
                             input logic [31:0] d, output int n);
    wr_t w;
    wait_until(m_free_at);
    n = cyc;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_offset = off;
    cmd_be = be; cmd_data = d; cmd_tag = 8'($urandom);
    w.addr = bar_addr(base_address_register, off); w.be = be; w.data = d;
    exp_wr[n + 1]   = w;
    exp_busy[n + 1] = 1'b1;
    m_free_at = n + 2;
  endtask

  // Read accepted in the current cycle; replies must already be scheduled.
  task automatic issue_read(input logic [10:0] off, input logic [7:0] tag, output int n);
    logic [15:0] lo;
    rq_t  q;
    res_t r;
    int   rc;
    n = cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_offset = off;
    cmd_be = 4'($urandom); cmd_data = $urandom; cmd_tag = tag;
    lo = {m_seq, tag};
    q.addr = bar_addr(base_address_register, off);
    q.ctx  = {72'h0, lo};
    exp_rq[n + 1] = q;
    m_seq = m_seq + 8'd1;
    rc = n + 2 + T; r.tag = tag; r.data = 32'hFFFF_FFFF; r.tmo = 1'b1;
    for (int c = n + 2; c <= n + 1 + T; c++) begin
      if (rsp_sched.exists(c) && rsp_sched[c].ctx[15:0] == lo) begin
        rc = c + 1; r.data = rsp_sched[c].data; r.tmo = 1'b0;
        stray_evt[c] = 1'b0;
        break;
      end
    end
    exp_res[rc] = r;
    for (int c = n + 1; c <= rc; c++) exp_busy[c] = 1'b1;
    m_free_at = rc + 1;
  endtask

  // delay < 0: no reply; otherwise a matching reply delay cycles after rd_req.
  task automatic read_op(input logic [10:0] off, input logic [7:0] tag, input int delay,
                         input logic [31:0] d, output int n);
    wait_until(m_free_at);
    if (delay >= 0) sched(cyc + 1 + delay, {m_seq, tag}, d);
    issue_read(off, tag, n);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int  k;
    bit  eb;
    k = cyc;
    if (prev_rst) begin
      m_stray = '0; m_tmo = '0; m_last = '0;
    end else if (stray_evt.exists(k - 1) && stray_evt[k - 1]) begin
      if (m_stray != 8'hFF) m_stray = m_stray + 8'd1;
    end
    if (!prev_rst && exp_res.exists(k) && exp_res[k].tmo && m_tmo != 16'hFFFF)
      m_tmo = m_tmo + 16'd1;
    if (rst) begin
      chk("rst_ready", cmd_ready, 0);
      chk("rst_ctrl", {wr_valid, rd_req_valid, res_valid, busy}, 0);
      chk("rst_wr", {wr_addr, wr_be, wr_data}, 0);
      chk("rst_rd", {rd_req_addr, rd_req_ctx}, 0);
      chk("rst_res", {res_tag, res_data, res_timeout}, 0);
      chk("rst_cnt", {timeout_count, stray_count}, 0);
    end else begin
      eb = exp_busy.exists(k);
      chk("cmd_ready", cmd_ready, !eb);
      chk("busy", busy, eb);
      chk("wr_valid", wr_valid, exp_wr.exists(k));
      if (exp_wr.exists(k)) chk("wr_fields", {wr_addr, wr_be, wr_data}, exp_wr[k]);
      chk("rd_req_valid", rd_req_valid, exp_rq.exists(k));
      if (exp_rq.exists(k)) chk("rd_req_fields", {rd_req_addr, rd_req_ctx}, exp_rq[k]);
      chk("res_valid", res_valid, exp_res.exists(k));
      if (exp_res.exists(k)) begin
        chk("res_fields", {res_tag, res_data, res_timeout}, exp_res[k]);
        m_last = exp_res[k];
      end else begin
        chk("res_hold", {res_tag, res_data, res_timeout}, m_last);
      end
      chk("one_request", wr_valid && rd_req_valid, 0);
      chk("timeout_count", timeout_count, m_tmo);
      chk("stray_count", stray_count, m_stray);
    end
    prev_rst = rst;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] lost;
    logic [7:0]  s;

    // Power-up reset; ready must rise in the first released cycle.
    do_reset(3);
    #1;
    chk("ready_first_cycle", cmd_ready, 1);

    // Write at offset 0x050.
    issue_write(11'h050, 4'hF, 32'h0001_0000, n);
    wait_until(n + 1);
    chk("w_valid", wr_valid, 1);
    chk("w_addr", wr_addr, 32'hF7C0_0050);
    tick();
    chk("w_single", wr_valid, 0);
    chk("w_ready_again", cmd_ready, 1);

    // Write with unaligned offset bits and a reply arriving during WR (stray).
    wait_until(m_free_at);
    sched(cyc + 1, 16'h0000, 32'h1);
    issue_write(11'h7FF, 4'h3, 32'hDEAD_BEEF, n);
    wait_until(n + 1);
    chk("w2_addr", wr_addr, 32'hF7C0_07FC);
    chk("w2_be", wr_be, 4'h3);

    // Read with a reply two cycles after the request.
    read_op(11'h00C, 8'h5A, 2, 32'h3F, n);
    wait_until(n + 1);
    chk("r_ctx", rd_req_ctx[15:0], 16'h005A);
    chk("r_addr", rd_req_addr, 32'hF7C0_000C);
    wait_until(n + 4);
    chk("r_res_valid", res_valid, 1);
    chk("r_res", {res_tag, res_data, res_timeout}, {8'h5A, 32'h3F, 1'b0});

    // Read never answered, then a late reply for it.
    wait_until(m_free_at);
    lost = {m_seq, 8'hC3};
    read_op(11'h010, 8'hC3, -1, 32'h0, n);
    wait_until(n + 2 + T);
    chk("t_res", {res_valid, res_data, res_timeout}, {1'b1, 32'hFFFF_FFFF, 1'b1});
    chk("t_count", timeout_count, 16'd1);
    chk("t_stray_before", stray_count, 8'd1);
    sched(cyc + 2, lost, 32'h5555_5555);
    wait_until(cyc + 3);
    chk("t_stray_after", stray_count, 8'd2);

    // Wrong sequence number first, then the right reply.
    wait_until(m_free_at);
    s = m_seq;
    sched(cyc + 3, {s + 8'd1, 8'h77}, 32'h0BAD_0BAD);
    sched(cyc + 5, {s, 8'h77}, 32'h1111_2222);
    issue_read(11'h020, 8'h77, n);
    wait_until(n + 6);
    chk("ws_res", {res_valid, res_tag, res_data, res_timeout}, {1'b1, 8'h77, 32'h1111_2222, 1'b0});
    chk("ws_stray", stray_count, 8'd3);

    // Reply on the final wait cycle wins over the timeout.
    read_op(11'h024, 8'h88, T, 32'hCAFE_F00D, n);
    wait_until(n + 2 + T);
    chk("last_res", {res_valid, res_data, res_timeout}, {1'b1, 32'hCAFE_F00D, 1'b0});
    chk("last_tmo", timeout_count, 16'd1);

    // Reply one cycle too late: timeout plus a stray.
    read_op(11'h028, 8'h99, T + 1, 32'h1234_5678, n);
    wait_until(n + 2 + T);
    chk("late_res", {res_valid, res_data, res_timeout}, {1'b1, 32'hFFFF_FFFF, 1'b1});

    // Idle-time stray reply.
    wait_until(m_free_at + 2);
    sched(cyc + 1, 16'hBEEF, 32'h0);

    // Reset during RD_WAIT abandons the read; a reply for it later is a stray.
    wait_until(m_free_at + 3);
    lost = {m_seq, 8'h42};
    read_op(11'h030, 8'h42, -1, 32'h0, n);
    wait_until(n + 10);
    do_reset(2);
    #1;
    chk("rr_ready", cmd_ready, 1);
    chk("rr_counts", {timeout_count, stray_count}, 0);
    sched(cyc + 1, lost, 32'h7);
    wait_until(cyc + 3);
    chk("rr_stray", stray_count, 8'd1);

    // 256 back-to-back reads, then one more after the sequence wraps.
    for (int i = 0; i < 256; i++) begin
      read_op(11'(i * 4), 8'(i), 1, 32'h0101_0101 * 32'(i), n);
    end
    read_op(11'h044, 8'hE1, 1, 32'hABCD_0001, n);
    wait_until(n + 1);
    chk("wrap_seq", rd_req_ctx[15:8], 8'h00);
    wait_until(n + 3);
    chk("wrap_res", {res_valid, res_data}, {1'b1, 32'hABCD_0001});

    wait_until(m_free_at + 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
